// File: rtl/core_if_fetch.sv
// Instruction fetch unit: issues word fetches, buffers responses in an in-order
// FIFO and presents them to decode; redirects flush the buffer and drop stale responses.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_if_fetch #(
   parameter logic [`CORE_XLEN-1:0] RESET_PC   = 32'h8000_0000,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        o_ifu_req_valid,
   input  logic                        i_ifu_req_ready,
   output logic [`CORE_XLEN-1:0]       o_ifu_req_addr,
   input  logic                        i_ifu_rsp_valid,
   input  logic [`CORE_INST_WIDTH-1:0] i_ifu_rsp_data,
   input  logic                        i_ifu_rsp_err,
   output logic                        o_inst_valid,
   input  logic                        i_inst_ready,
   output logic [`CORE_INST_WIDTH-1:0] o_inst,
   output logic [`CORE_XLEN-1:0]       o_inst_pc,
   output logic                        o_inst_err,
   input  logic                        i_redirect_valid,
   input  logic [`CORE_XLEN-1:0]       i_redirect_pc
);
   localparam int XW    = `CORE_XLEN;
   localparam int IW    = `CORE_INST_WIDTH;
   localparam int SLOTS = 4;   // storage sized for the largest legal depth
   localparam int CW    = 3;
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [1:0]    LAST_PTR = 2'(FIFO_DEPTH - 1);

   logic [XW-1:0] fetch_pc_reg;
   logic [XW-1:0] deliver_pc_reg;
   logic [CW-1:0] outstanding_reg;
   logic [CW-1:0] drop_cnt_reg;
   logic [CW-1:0] fifo_count_reg;
   logic [1:0]    rd_ptr_reg;
   logic [1:0]    wr_ptr_reg;
   logic          halted_reg;
   logic [IW-1:0] data_mem [SLOTS];
   logic          err_mem  [SLOTS];

   logic [CW-1:0] in_use;
   logic          req_fire;
   logic          rsp_keep;
   logic          deq;
   logic [XW-1:0] redirect_base;
   logic [1:0]    rd_ptr_next;
   logic [1:0]    wr_ptr_next;
   logic          unused_pc_bits;

   assign in_use         = outstanding_reg + fifo_count_reg;
   assign redirect_base  = {i_redirect_pc[XW-1:2], 2'b00};
   assign unused_pc_bits = &{1'b1, i_redirect_pc[1:0]};

   // rst_n gates the request so nothing is offered while reset is held
   assign o_ifu_req_valid = rst_n & ~halted_reg & ~i_redirect_valid
                          & (in_use < DEPTH_C) & (drop_cnt_reg == '0);
   assign o_ifu_req_addr  = fetch_pc_reg;

   assign req_fire = o_ifu_req_valid & i_ifu_req_ready;
   assign rsp_keep = i_ifu_rsp_valid & (drop_cnt_reg == '0);
   assign deq      = o_inst_valid & i_inst_ready;

   assign rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? 2'd0 : rd_ptr_reg + 2'd1;
   assign wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? 2'd0 : wr_ptr_reg + 2'd1;

   assign o_inst_valid = (fifo_count_reg != '0);
   assign o_inst       = data_mem[rd_ptr_reg];
   assign o_inst_err   = err_mem[rd_ptr_reg];
   assign o_inst_pc    = deliver_pc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_reg    <= RESET_PC;
         deliver_pc_reg  <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
         fifo_count_reg  <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         halted_reg      <= 1'b0;
      end else if (i_redirect_valid) begin
         fetch_pc_reg   <= redirect_base;
         deliver_pc_reg <= redirect_base;
         fifo_count_reg <= '0;
         rd_ptr_reg     <= '0;
         wr_ptr_reg     <= '0;
         halted_reg     <= 1'b0;
         // a response landing now is stale too, so it is not counted as a drop
         if (i_ifu_rsp_valid) begin
            outstanding_reg <= outstanding_reg - CW'(1);
            drop_cnt_reg    <= outstanding_reg - CW'(1);
         end else begin
            drop_cnt_reg    <= outstanding_reg;
         end
      end else begin
         if (req_fire)
            fetch_pc_reg <= fetch_pc_reg + XW'(4);
         case ({req_fire, i_ifu_rsp_valid})
            2'b10:   outstanding_reg <= outstanding_reg + CW'(1);
            2'b01:   outstanding_reg <= outstanding_reg - CW'(1);
            default: ;
         endcase
         if (i_ifu_rsp_valid && drop_cnt_reg != '0)
            drop_cnt_reg <= drop_cnt_reg - CW'(1);
         if (rsp_keep) begin
            wr_ptr_reg <= wr_ptr_next;
            if (i_ifu_rsp_err)
               halted_reg <= 1'b1;
         end
         if (deq) begin
            rd_ptr_reg     <= rd_ptr_next;
            deliver_pc_reg <= deliver_pc_reg + XW'(4);
         end
         fifo_count_reg <= fifo_count_reg + CW'(rsp_keep) - CW'(deq);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) begin
            data_mem[i] <= '0;
            err_mem[i]  <= 1'b0;
         end
      end else if (rsp_keep && !i_redirect_valid) begin
         data_mem[wr_ptr_reg] <= i_ifu_rsp_data;
         err_mem[wr_ptr_reg]  <= i_ifu_rsp_err;
      end
   end

endmodule
